// File: rtl/cmd_exec_if.sv
// Command/response handshake between the UART command wrapper (master) and the
// command execution stage (slave).
interface cmd_exec_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        snd_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    modport master (
        output cmd, data, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, snd_resp, resp
    );

    modport slave (
        input  cmd, data, cmd_rdy, resp_sent,
        output clr_cmd_rdy, snd_resp, resp
    );
endinterface

// File: rtl/cmd_exec.sv
// Command execution stage: decodes wrapper commands against a bank of 16-bit config
// registers and answers with one response byte. Define CMD_TMO_EN for the link-loss timeout.
module cmd_exec #(
    parameter int          NUM_REGS   = 8,
    parameter logic [7:0]  ACK_BYTE   = 8'hA5,
    parameter logic [7:0]  NAK_BYTE   = 8'hEE,
    parameter logic [31:0] TMO_CYCLES = 32'd2_500_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cmd_exec_if.slave               bus,
    output logic                    busy,
    output logic [16*NUM_REGS-1:0]  regs,
    output logic                    tmo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_RD_LO = 4'h2;
    localparam logic [3:0] OP_RD_HI = 4'h3;
    localparam logic [3:0] OP_INCR  = 4'h4;

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [1:0]       state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [15:0]      data_q, data_d;
    logic             clr_q, clr_d;
    logic             snd_q, snd_d;
    logic [7:0]       resp_q, resp_d;
    logic             resp_sent_q;
    logic             busy_q;
    logic [15:0]      regs_q [NUM_REGS];
    logic [15:0]      regs_d [NUM_REGS];

    logic             accept;
    logic [3:0]       op;
    logic [3:0]       idx;
    logic             idx_ok;
    logic [IDX_W-1:0] sel;
    logic             tmo_fire;

    assign accept = (state_q == S_IDLE) && bus.cmd_rdy;
    assign op     = cmd_q[7:4];
    assign idx    = cmd_q[3:0];
    assign idx_ok = int'(idx) < NUM_REGS;
    assign sel    = idx[IDX_W-1:0];

`ifdef CMD_TMO_EN
    logic [31:0] tmo_cnt_q;
    logic        tmo_q;

    // Fires once per idle stretch; the counter parks at the terminal value afterwards.
    assign tmo_fire = !tmo_q && !accept && (tmo_cnt_q == TMO_CYCLES - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (accept) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (tmo_cnt_q != TMO_CYCLES - 32'd1) tmo_cnt_q <= tmo_cnt_q + 32'd1;
            if (tmo_fire)                        tmo_q     <= 1'b1;
        end
    end

    assign tmo = tmo_q;
`else
    assign tmo_fire = 1'b0;
    assign tmo      = 1'b0;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        clr_d   = 1'b0;
        snd_d   = 1'b0;
        resp_d  = resp_q;
        regs_d  = regs_q;

        // The timeout clear is applied first so a same-edge command write overrides it.
        if (tmo_fire) regs_d[0] = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cmd_d   = bus.cmd;
                    data_d  = bus.data;
                    clr_d   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                snd_d   = 1'b1;
                state_d = S_WAIT;
                resp_d  = NAK_BYTE;
                if (op == OP_NOP) begin
                    resp_d = ACK_BYTE;
                end else if (idx_ok) begin
                    case (op)
                        OP_WRITE: begin
                            regs_d[sel] = data_q;
                            resp_d      = ACK_BYTE;
                        end
                        OP_RD_LO: resp_d = regs_q[sel][7:0];
                        OP_RD_HI: resp_d = regs_q[sel][15:8];
                        OP_INCR: begin
                            regs_d[sel] = regs_q[sel] + data_q;
                            resp_d      = ACK_BYTE;
                        end
                        default:  resp_d = NAK_BYTE;
                    endcase
                end
            end
            S_WAIT: begin
                if (bus.resp_sent && !resp_sent_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            data_q      <= '0;
            clr_q       <= 1'b0;
            snd_q       <= 1'b0;
            resp_q      <= '0;
            resp_sent_q <= 1'b0;
            busy_q      <= 1'b0;
            // NOTE: the bank drives live configuration, so every entry is reset (not a RAM).
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            clr_q       <= clr_d;
            snd_q       <= snd_d;
            resp_q      <= resp_d;
            resp_sent_q <= bus.resp_sent;
            busy_q      <= (state_d != S_IDLE);
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < NUM_REGS; i++) regs[16*i +: 16] = regs_q[i];
    end

    assign bus.clr_cmd_rdy = clr_q;
    assign bus.snd_resp    = snd_q;
    assign bus.resp        = resp_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Directed bench for cmd_exec: vector table of commands plus hand-written
// back-to-back, mid-operation reset and idle-timeout sequences.
module tb_cmd_exec;

    localparam int NUM_REGS = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic tmo;
    logic [16*NUM_REGS-1:0] regs;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_regs [NUM_REGS];

    cmd_exec_if bus ();

    cmd_exec #(
        .NUM_REGS  (NUM_REGS),
        .ACK_BYTE  (8'hA5),
        .NAK_BYTE  (8'hEE),
        .TMO_CYCLES(32'd100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy),
        .regs (regs),
        .tmo  (tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [7:0]  exp_resp;
        logic        upd;
        int          ridx;
        logic [15:0] exp_reg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("%s_reg%0d", name, i), {16'h0, regs[16*i +: 16]}, {16'h0, exp_regs[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command: wrapper presents it, clears cmd_rdy on clr pulse, UART acks later.
    task automatic run_cmd(input logic [7:0] c, input logic [15:0] d);
        bus.cmd     = c;
        bus.data    = d;
        bus.cmd_rdy = 1'b1;
        tick();
        check("clr_pulse", {31'h0, bus.clr_cmd_rdy}, 32'd1);
        check("busy_exec", {31'h0, busy}, 32'd1);
        bus.cmd_rdy = 1'b0;
        bus.cmd     = ~c;
        bus.data    = ~d;
        tick();
        check("snd_pulse", {31'h0, bus.snd_resp}, 32'd1);
        check("clr_once", {31'h0, bus.clr_cmd_rdy}, 32'd0);
        tick();
        check("snd_once", {31'h0, bus.snd_resp}, 32'd0);
        bus.resp_sent = 1'b1;
        tick();
        bus.resp_sent = 1'b0;
        check("idle_after", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [16];
        vecs[0]  = '{8'h12, 16'hBEEF, 8'hA5, 1'b1, 2, 16'hBEEF};
        vecs[1]  = '{8'h22, 16'h0000, 8'hEF, 1'b0, 0, 16'h0000};
        vecs[2]  = '{8'h32, 16'h0000, 8'hBE, 1'b0, 0, 16'h0000};
        vecs[3]  = '{8'h11, 16'hFFFE, 8'hA5, 1'b1, 1, 16'hFFFE};
        vecs[4]  = '{8'h41, 16'h0003, 8'hA5, 1'b1, 1, 16'h0001};
        vecs[5]  = '{8'h1F, 16'h1234, 8'hEE, 1'b0, 0, 16'h0000};
        vecs[6]  = '{8'h70, 16'h5555, 8'hEE, 1'b0, 0, 16'h0000};
        vecs[7]  = '{8'h00, 16'h0000, 8'hA5, 1'b0, 0, 16'h0000};
        vecs[8]  = '{8'h0F, 16'hFFFF, 8'hA5, 1'b0, 0, 16'h0000};
        vecs[9]  = '{8'h47, 16'h0005, 8'hA5, 1'b1, 7, 16'h0005};
        vecs[10] = '{8'h27, 16'h0000, 8'h05, 1'b0, 0, 16'h0000};
        vecs[11] = '{8'h18, 16'hAAAA, 8'hEE, 1'b0, 0, 16'h0000};
        vecs[12] = '{8'h17, 16'hFFFF, 8'hA5, 1'b1, 7, 16'hFFFF};
        vecs[13] = '{8'h47, 16'h0001, 8'hA5, 1'b1, 7, 16'h0000};
        vecs[14] = '{8'hF3, 16'h0000, 8'hEE, 1'b0, 0, 16'h0000};
        vecs[15] = '{8'h34, 16'h0000, 8'h00, 1'b0, 0, 16'h0000};

        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
        rst_n         = 1'b0;
        bus.cmd       = '0;
        bus.data      = '0;
        bus.cmd_rdy   = 1'b0;
        bus.resp_sent = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_clr", {31'h0, bus.clr_cmd_rdy}, 32'd0);
        check("rst_snd", {31'h0, bus.snd_resp}, 32'd0);
        check("rst_resp", {24'h0, bus.resp}, 32'h0);
        check("rst_tmo", {31'h0, tmo}, 32'd0);
        check_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 16; v++) begin
            run_cmd(vecs[v].cmd, vecs[v].data);
            if (vecs[v].upd) exp_regs[vecs[v].ridx] = vecs[v].exp_reg;
            check($sformatf("vec%0d_resp", v), {24'h0, bus.resp}, {24'h0, vecs[v].exp_resp});
            check_regs($sformatf("vec%0d", v));
        end

        // Back-to-back: resp_sent left high from the previous transfer must not release WAIT.
        bus.cmd = 8'h13; bus.data = 16'h1234; bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b0;
        tick();
        check("b2b1_resp", {24'h0, bus.resp}, 32'hA5);
        tick();
        bus.resp_sent = 1'b1;
        tick();
        check("b2b1_idle", {31'h0, busy}, 32'd0);
        exp_regs[3] = 16'h1234;
        bus.cmd = 8'h23; bus.data = 16'h0000; bus.cmd_rdy = 1'b1;
        tick();
        check("b2b2_clr", {31'h0, bus.clr_cmd_rdy}, 32'd1);
        bus.cmd_rdy = 1'b0;
        tick();
        check("b2b2_snd", {31'h0, bus.snd_resp}, 32'd1);
        check("b2b2_resp", {24'h0, bus.resp}, 32'h34);
        bus.cmd = 8'h13; bus.data = 16'h5678; bus.cmd_rdy = 1'b1;
        begin
            int clr_seen = 0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (bus.clr_cmd_rdy) clr_seen++;
            end
            check("b2b_no_early_clr", clr_seen, 0);
        end
        check("b2b_wait_busy", {31'h0, busy}, 32'd1);
        check("b2b_reg3_held", {16'h0, regs[63:48]}, 32'h1234);
        bus.resp_sent = 1'b0;
        tick();
        check("b2b_still_wait", {31'h0, busy}, 32'd1);
        bus.resp_sent = 1'b1;
        tick();
        check("b2b_release", {31'h0, busy}, 32'd0);
        tick();
        check("b2b3_clr", {31'h0, bus.clr_cmd_rdy}, 32'd1);
        bus.cmd_rdy = 1'b0; bus.resp_sent = 1'b0;
        tick();
        check("b2b3_snd", {31'h0, bus.snd_resp}, 32'd1);
        exp_regs[3] = 16'h5678;
        check_regs("b2b3");
        tick();
        bus.resp_sent = 1'b1;
        tick();
        bus.resp_sent = 1'b0;
        check("b2b3_idle", {31'h0, busy}, 32'd0);

        // Reset while a write is between accept and execute: the write is dropped.
        bus.cmd = 8'h15; bus.data = 16'hAAAA; bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_clr", {31'h0, bus.clr_cmd_rdy}, 32'd0);
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
        check_regs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("mid_rst_no_snd", {31'h0, bus.snd_resp}, 32'd0);
        check("mid_rst_idle", {31'h0, busy}, 32'd0);
        check("mid_rst_reg5", {16'h0, regs[95:80]}, 32'h0);

        // Idle timeout behaviour (counter cleared at the accept inside run_cmd).
        run_cmd(8'h10, 16'h0001);
        check("tmo_reg0_set", {16'h0, regs[15:0]}, 32'h0001);
        repeat (50) tick();
        check("tmo_early", {31'h0, tmo}, 32'd0);
        repeat (70) tick();
`ifdef CMD_TMO_EN
        check("tmo_set", {31'h0, tmo}, 32'd1);
        check("tmo_reg0_clr", {16'h0, regs[15:0]}, 32'h0);
        run_cmd(8'h00, 16'h0000);
        check("tmo_cleared", {31'h0, tmo}, 32'd0);
        check("tmo_nop_resp", {24'h0, bus.resp}, 32'hA5);
        check("tmo_reg0_stays", {16'h0, regs[15:0]}, 32'h0);
`else
        check("tmo_tied", {31'h0, tmo}, 32'd0);
        check("tmo_reg0_kept", {16'h0, regs[15:0]}, 32'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
